// File: rtl/cpu_data.sv
// Shared CPU definitions: ALU operation codes, execute-FSM state encoding,
// status flag bit positions and small decode helpers used by alu_exec.
package cpu_data;

    // ALU operation codes carried on op_code / alu_operator
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_MOV = 4'h5;
    localparam logic [3:0] OP_CMP = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;

    // Status flag bit positions within {C,V,Z,N}
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // Execute sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } exec_state_t;

    // Binary compare only updates flags, never the destination register
    function automatic logic op_writes_reg(input logic [3:0] code, input logic single);
        return !(!single && (code == OP_CMP));
    endfunction

    // Binary move copies a value and leaves the status register alone
    function automatic logic op_writes_flags(input logic [3:0] code, input logic single);
        return !(!single && (code == OP_MOV));
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Eight 8-bit registers: two operand read ports, one debug read port and a
// single write port. Optional macro ALU_EXEC_R0ZERO_EN hard-wires R0 to zero.
module alu_regfile
    import cpu_data::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr1,
    input  logic [2:0] raddr2,
    input  logic [2:0] dbg_addr,
    output logic [7:0] rdata1,
    output logic [7:0] rdata2,
    output logic [7:0] dbg_data
);

    logic [7:0] regs [8];
    logic       wr_en;

    // Write enable qualification (R0 is read-only when hard-wired to zero)
    always_comb begin
`ifdef ALU_EXEC_R0ZERO_EN
        wr_en = we && (waddr != 3'd0);
`else
        wr_en = we;
`endif
    end

    // Register storage with asynchronous clear
    // NOTE: this small array is reset deliberately because software relies on
    // all registers reading zero after reset; large RAMs normally are not reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (wr_en) begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            regs[waddr] <= wdata;
        end
    end

    // Combinational read ports
    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        rdata1   = regs[raddr1];
        rdata2   = regs[raddr2];
        dbg_data = regs[dbg_addr];
`ifdef ALU_EXEC_R0ZERO_EN
        if (raddr1 == 3'd0)   rdata1   = 8'h00;
        if (raddr2 == 3'd0)   rdata2   = 8'h00;
        if (dbg_addr == 3'd0) dbg_data = 8'h00;
`endif
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: accepts one decoded operation, reads operands from the
// register file, strobes an external ALU and writes back result and flags.
// Optional macro ALU_EXEC_R0ZERO_EN makes R0 a constant-zero register.
module alu_exec
    import cpu_data::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op_code,
    input  logic       op_single,
    input  logic [2:0] op_rd,
    input  logic [2:0] op_rs,
    input  logic       ld_valid,
    input  logic [2:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic       alu_cs_in,
    output logic       alu_cs_out,
    output logic       alu_cs_flags,
    output logic       alu_single,
    output logic [7:0] alu_value1,
    output logic [7:0] alu_value2,
    output logic [3:0] alu_operator,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic [3:0] flags,
    output logic       done,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    exec_state_t state, state_nxt;

    logic [3:0] code_q;
    logic       single_q;
    logic [2:0] rd_q;
    logic [2:0] rs_q;

    logic       accept;
    logic       ld_we;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [7:0] rf_rdata1;
    logic [7:0] rf_rdata2;

    // A pending load owns the write port, so it blocks acceptance that cycle
    assign ld_we    = ld_valid && (state == ST_IDLE);
    assign op_ready = (state == ST_IDLE) && !ld_valid && !rst;
    assign accept   = op_valid && op_ready;

    // Single write port shared by direct loads (IDLE) and writeback (WRITE)
    assign rf_we    = ld_we || ((state == ST_WRITE) && op_writes_reg(code_q, single_q));
    assign rf_waddr = ld_we ? ld_addr : rd_q;
    assign rf_wdata = ld_we ? ld_data : alu_result;

    alu_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr1   (rd_q),
        .raddr2   (rs_q),
        .dbg_addr (dbg_addr),
        .rdata1   (rf_rdata1),
        .rdata2   (rf_rdata2),
        .dbg_data (dbg_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: fixed four-step sequence once an op is accepted
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ALU strobes and completion pulse decoded from the current state
    always_comb begin
        alu_cs_in    = 1'b0;
        alu_cs_out   = 1'b0;
        alu_cs_flags = 1'b0;
        done         = 1'b0;
        case (state)
            ST_EXEC: alu_cs_in = 1'b1;
            ST_WRITE: begin
                alu_cs_in    = 1'b1;
                alu_cs_out   = 1'b1;
                alu_cs_flags = 1'b1;
                done         = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_single   = single_q;
    assign alu_operator = code_q;

    // Capture the operation on accept so later input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q   <= 4'h0;
            single_q <= 1'b0;
            rd_q     <= 3'd0;
            rs_q     <= 3'd0;
        end else if (accept) begin
            code_q   <= op_code;
            single_q <= op_single;
            rd_q     <= op_rd;
            rs_q     <= op_rs;
        end
    end

    // Operand latches loaded in READ and held stable until the next READ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_value1 <= 8'h00;
            alu_value2 <= 8'h00;
        end else if (state == ST_READ) begin
            alu_value1 <= rf_rdata1;
            alu_value2 <= rf_rdata2;
        end
    end

    // Status register updated at the end of WRITE unless the op preserves it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 4'h0;
        end else if ((state == ST_WRITE) && op_writes_flags(code_q, single_q)) begin
            flags <= alu_flags;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec with a behavioural ALU attached to its ALU bus.
module tb_alu_exec;
    import cpu_data::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_code;
    logic       op_single;
    logic [2:0] op_rd;
    logic [2:0] op_rs;
    logic       ld_valid;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic       alu_cs_in;
    logic       alu_cs_out;
    logic       alu_cs_flags;
    logic       alu_single;
    logic [7:0] alu_value1;
    logic [7:0] alu_value2;
    logic [3:0] alu_operator;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic [3:0] flags;
    logic       done;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_code      (op_code),
        .op_single    (op_single),
        .op_rd        (op_rd),
        .op_rs        (op_rs),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .alu_cs_in    (alu_cs_in),
        .alu_cs_out   (alu_cs_out),
        .alu_cs_flags (alu_cs_flags),
        .alu_single   (alu_single),
        .alu_value1   (alu_value1),
        .alu_value2   (alu_value2),
        .alu_operator (alu_operator),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .flags        (flags),
        .done         (done),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Behavioural ALU: result and {C,V,Z,N} from the operand bus
    always_comb begin
        logic [8:0] wide;
        logic       c;
        logic       v;
        wide = 9'h000;
        c    = 1'b0;
        v    = 1'b0;
        case (alu_operator)
            OP_ADD: begin
                wide = {1'b0, alu_value1} + {1'b0, alu_value2};
                c    = wide[8];
                v    = (alu_value1[7] == alu_value2[7]) && (wide[7] != alu_value1[7]);
            end
            OP_SUB, OP_CMP: begin
                wide = {1'b0, alu_value1} - {1'b0, alu_value2};
                c    = wide[8];
                v    = (alu_value1[7] != alu_value2[7]) && (wide[7] != alu_value1[7]);
            end
            OP_AND: wide = {1'b0, alu_value1 & alu_value2};
            OP_OR:  wide = {1'b0, alu_value1 | alu_value2};
            OP_XOR: wide = {1'b0, alu_value1 ^ alu_value2};
            OP_MOV: wide = {1'b0, alu_value2};
            OP_NOT: wide = {1'b0, ~alu_value1};
            OP_INC: wide = {1'b0, alu_value1 + 8'h01};
            default: wide = 9'h000;
        endcase
        alu_result = wide[7:0];
        alu_flags  = {c, v, (wide[7:0] == 8'h00), wide[7]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, {24'h0, dbg_data}, {24'h0, exp});
    endtask

    // Direct register load; called just after a negedge while idle
    task automatic do_load(input logic [2:0] addr, input logic [7:0] data);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    // Issue one op, check strobes/operands/latency, return in the following IDLE cycle
    task automatic run_op(input string tag, input logic [3:0] code, input logic single,
                          input logic [2:0] rd, input logic [2:0] rs,
                          input logic [7:0] e1, input logic [7:0] e2, input bit stray_ld);
        int  n;
        bit  seen;
        op_valid  = 1'b1;
        op_code   = code;
        op_single = single;
        op_rd     = rd;
        op_rs     = rs;
        #1;
        check({tag, ":ready"}, {31'h0, op_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        // READ: scramble the op inputs to prove they were latched
        op_valid  = 1'b0;
        op_code   = ~code;
        op_single = ~single;
        op_rd     = ~rd;
        op_rs     = ~rs;
        if (stray_ld) begin
            ld_valid = 1'b1;
            ld_addr  = 3'd2;
            ld_data  = 8'h77;
        end
        check({tag, ":busy"}, {31'h0, op_ready}, 32'h0);
        @(negedge clk);
        // EXEC
        check({tag, ":exec_strb"}, {29'h0, alu_cs_in, alu_cs_out, done}, 32'h4);
        check({tag, ":exec_op"}, {27'h0, alu_single, alu_operator}, {27'h0, single, code});
        check({tag, ":operands"}, {16'h0, alu_value1, alu_value2}, {16'h0, e1, e2});
        n    = 2;
        seen = 1'b0;
        while (n < 8 && !seen) begin
            @(negedge clk);
            n++;
            seen = done;
        end
        check({tag, ":latency"}, n, 3);
        check({tag, ":wr_strb"}, {29'h0, alu_cs_in, alu_cs_out, alu_cs_flags}, 32'h7);
        ld_valid = 1'b0;
        @(negedge clk);
        check({tag, ":idle"}, {30'h0, op_ready, done}, 32'h2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;
        rst       = 1'b1;
        op_valid  = 1'b0;
        op_code   = 4'h0;
        op_single = 1'b0;
        op_rd     = 3'd0;
        op_rs     = 3'd0;
        ld_valid  = 1'b0;
        ld_addr   = 3'd0;
        ld_data   = 8'h00;
        dbg_addr  = 3'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {24'h0, op_ready, done, alu_cs_in, alu_cs_out, flags}, 32'h0);
        check("rst_operands", {16'h0, alu_value1, alu_value2}, 32'h0);
        check_reg("rst_r3", 3'd3, 8'h00);
        rst = 1'b0;
        #1;
        check("rst_release_ready", {31'h0, op_ready}, 32'h1);
        @(negedge clk);

        // ADD R1=5 + R2=3
        do_load(3'd1, 8'h05);
        do_load(3'd2, 8'h03);
        check_reg("ld_r1", 3'd1, 8'h05);
        run_op("add", OP_ADD, 1'b0, 3'd1, 3'd2, 8'h05, 8'h03, 1'b0);
        check_reg("add_r1", 3'd1, 8'h08);
        check_reg("add_r2", 3'd2, 8'h03);
        check("add_flags", {28'h0, flags}, 32'h0);

        // CMP 5-5: Z only, no register write
        do_load(3'd1, 8'h05);
        do_load(3'd2, 8'h05);
        run_op("cmp", OP_CMP, 1'b0, 3'd1, 3'd2, 8'h05, 8'h05, 1'b0);
        check_reg("cmp_r1", 3'd1, 8'h05);
        check("cmp_flags", {28'h0, flags}, 32'h2);

        // FF+02 = 01 with carry out -> flags 1000
        do_load(3'd6, 8'hFF);
        do_load(3'd7, 8'h02);
        run_op("addc", OP_ADD, 1'b0, 3'd6, 3'd7, 8'hFF, 8'h02, 1'b0);
        check_reg("addc_r6", 3'd6, 8'h01);
        check("addc_flags", {28'h0, flags}, 32'h8);

        // MOV keeps flags
        do_load(3'd1, 8'h7F);
        run_op("mov", OP_MOV, 1'b0, 3'd3, 3'd1, 8'h00, 8'h7F, 1'b0);
        check_reg("mov_r3", 3'd3, 8'h7F);
        check("mov_flags", {28'h0, flags}, 32'h8);

        // Reset during EXEC aborts the op
        op_valid  = 1'b1;
        op_code   = OP_ADD;
        op_single = 1'b0;
        op_rd     = 3'd1;
        op_rs     = 3'd2;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        check("abort_in_exec", {31'h0, alu_cs_in}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_outputs", {24'h0, op_ready, done, alu_cs_in, alu_cs_out, flags}, 32'h0);
        check_reg("abort_r1", 3'd1, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", {31'h0, op_ready}, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | done;
        end
        check("abort_no_done", {31'h0, seen}, 32'h0);
        check("abort_flags", {28'h0, flags}, 32'h0);

        // Load and op in the same IDLE cycle: load wins, op next cycle
        do_load(3'd2, 8'h33);
        ld_valid  = 1'b1;
        ld_addr   = 3'd4;
        ld_data   = 8'hAA;
        op_valid  = 1'b1;
        op_code   = OP_SUB;
        op_single = 1'b0;
        op_rd     = 3'd4;
        op_rs     = 3'd4;
        #1;
        check("ldop_blocked", {31'h0, op_ready}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        check_reg("ldop_r4", 3'd4, 8'hAA);
        // rd==rs reads AA twice; a load arriving mid-op must be dropped
        run_op("sub_same", OP_SUB, 1'b0, 3'd4, 3'd4, 8'hAA, 8'hAA, 1'b1);
        check_reg("sub_r4", 3'd4, 8'h00);
        check("sub_flags", {28'h0, flags}, 32'h2);
        check_reg("stray_ld_r2", 3'd2, 8'h33);

        // Back-to-back ops: second must see the first result
        do_load(3'd1, 8'h7F);
        run_op("b2b_add", OP_ADD, 1'b0, 3'd1, 3'd1, 8'h7F, 8'h7F, 1'b0);
        check("b2b_add_flags", {28'h0, flags}, 32'h5);
        run_op("b2b_not", OP_NOT, 1'b1, 3'd1, 3'd2, 8'hFE, 8'h33, 1'b0);
        check_reg("b2b_r1", 3'd1, 8'h01);
        check("b2b_not_flags", {28'h0, flags}, 32'h0);

        // R0 behaviour depends on build configuration
        do_load(3'd0, 8'hFF);
`ifdef ALU_EXEC_R0ZERO_EN
        check_reg("r0_dbg", 3'd0, 8'h00);
        run_op("mov_r0", OP_MOV, 1'b0, 3'd5, 3'd0, 8'h00, 8'h00, 1'b0);
        check_reg("mov_r0_r5", 3'd5, 8'h00);
`else
        check_reg("r0_dbg", 3'd0, 8'hFF);
        run_op("mov_r0", OP_MOV, 1'b0, 3'd5, 3'd0, 8'h00, 8'hFF, 1'b0);
        check_reg("mov_r0_r5", 3'd5, 8'hFF);
`endif

        n = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have port clk  in  1  single system clock, rising-edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports op_valid in 1 / op_ready out 1: operation handshake from decoder.
REQ-004 SHALL have ports op_code in 4 (`OP_*` code), op_single in 1 (unary op), op_rd in 3 (dest/value1 reg), op_rs in 3 (value2 reg).
REQ-005 SHALL have ports ld_valid in 1, ld_addr in 3, ld_data in 8: direct register load (memory writeback).
REQ-006 SHALL have ALU-side outputs alu_cs_in, alu_cs_out, alu_cs_flags, alu_single (1 each), alu_value1, alu_value2 (8 each), alu_operator (4).
REQ-007 SHALL have ALU-side inputs alu_result in 8 (ALU bus_in), alu_flags in 4 ({C,V,Z,N}).
REQ-008 SHALL have outputs flags out 4 ({C,V,Z,N} status register), done out 1 (completion pulse).
REQ-009 SHALL have debug port dbg_addr in 3 / dbg_data out 8: combinational read of R[dbg_addr].

Function
REQ-010 SHALL hold eight 8-bit registers R0..R7 and a 4-bit status register.
REQ-011 SHALL implement FSM IDLE -> READ -> EXEC -> WRITE -> IDLE; no other transitions except reset.
REQ-012 op_ready SHALL be 1 only in IDLE with ld_valid=0; op accepted on rising edge with op_valid&op_ready.
REQ-013 On accept SHALL latch op_code, op_single, op_rd, op_rs; later changes on op_* inputs ignored.
REQ-014 READ: SHALL latch alu_value1=R[rd], alu_value2=R[rs]; operands held stable through WRITE.
REQ-015 EXEC: alu_cs_in=1; alu_single, alu_operator driven from latched op; all other strobes 0.
REQ-016 WRITE: alu_cs_in=1, alu_cs_out=1, alu_cs_flags=1, done=1 for exactly this one cycle.
REQ-017 At end of WRITE SHALL write alu_result to R[rd], except binary `OP_CMP` (no register write).
REQ-018 At end of WRITE SHALL load alu_flags into flags, except binary `OP_MOV` (flags unchanged).
REQ-019 Latency: accept at edge T0; done high in cycle T3; R[rd]/flags visible T4; op_ready high T4.
REQ-020 rd==rs SHALL read the same register into both operands.
REQ-021 ld_valid in IDLE SHALL write ld_data to R[ld_addr] at that edge and block accept that cycle (load wins).
REQ-022 ld_valid outside IDLE SHALL be ignored (no write).
REQ-023 Back-to-back ops SHALL observe previous result (no stale read); max throughput one op per 4 cycles.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, R0..R7=0, flags=0, operands=0, all alu_cs_* =0, done=0, op_ready=0 while rst high.
REQ-025 Reset mid-operation SHALL abort the op with no register or flags write; op_ready=1 first cycle after rst falls.

Configuration
REQ-026 Macro ALU_EXEC_R0ZERO_EN defined: R0 SHALL read as 8'h00 on all read paths and writes to R0 (op or load) SHALL be discarded; flags still update.
REQ-027 Macro ALU_EXEC_R0ZERO_EN undefined: R0 SHALL be an ordinary register.

Structure
REQ-028 `OP_*` codes, FSM state encodings and flag bit indices SHALL live in shared cpu_data.v; none redefined locally.
REQ-029 Register storage with two read ports, one debug read port, one write port SHALL be sub-module alu_regfile; FSM, operand latches, flags in alu_exec.

Verification
REQ-030 Load R1=8'h05, R2=8'h03; binary `OP_ADD` rd=1 rs=2 with ALU model -> done in T3, R1=8'h08, R2 unchanged.
REQ-031 R1=8'h05, R2=8'h05; `OP_CMP` rd=1 rs=2 -> R1 stays 8'h05, flags = model's flags for 5-5.
REQ-032 flags=4'b1000, `OP_MOV` rd=3 rs=1 (R1=8'h7F) -> R3=8'h7F, flags stays 4'b1000.
REQ-033 ld_valid and op_valid same IDLE cycle (ld R4=8'hAA) -> R4=8'hAA, op_ready=0, op accepted next cycle.
REQ-034 Assert rst in EXEC of `OP_ADD` rd=1 -> R1=0, flags=0, no done pulse, op_ready=1 after release.
REQ-035 With ALU_EXEC_R0ZERO_EN: ld R0=8'hFF then `OP_MOV` rd=5 rs=0 -> R5=8'h00, dbg_addr=0 reads 8'h00.
